radio_deser: RTL and testbench

- Receive-side deserializer, directly downstream of the radio module's serial link.
- Consumes the bit stream (DATA_IN) and the frame marker (SYNC_IN), both produced in the serial clock domain.
- Acquires and holds frame alignment, then rebuilds each WORD_W-bit radio sample word.
- Presents each word, and the unpacked R0/R1 I/Q fields, with a one-cycle valid strobe to the correlator capture logic.

---
 rtl/radio_deser.sv | 185 ++++++++++++++++++
 tb/tb_radio_deser.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/radio_deser.sv
// Receive-side deserializer: acquires SYNC-based frame alignment on the serial link,
// keeps lock through isolated missing SYNCs and rebuilds LSB-first sample words.
module radio_deser #(
  parameter int WORD_W     = 8,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2
) (
  input  logic              SER_CLK,
  input  logic              RST_N,
  input  logic              DATA_IN,
  input  logic              SYNC_IN,
  output logic [WORD_W-1:0] WORD_OUT,
  output logic              WORD_VALID,
  output logic [1:0]        R0_I,
  output logic [1:0]        R0_Q,
  output logic [1:0]        R1_I,
  output logic [1:0]        R1_Q,
  output logic              LOCKED,
  output logic [7:0]        ERR_COUNT
);

  localparam int            CW       = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [3:0]    LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0]    LOSS_N   = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     bit_cnt_q;
  logic [CW-1:0]     bit_cnt_d;
  logic [3:0]        good_cnt_q;
  logic [3:0]        miss_cnt_q;
  logic [WORD_W-2:0] shift_q;
  logic [WORD_W-2:0] shift_d;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              locked_q;
  logic [7:0]        err_q;
  logic [7:0]        err_d;
  logic [CW-1:0]     wr_idx_s;
  logic              boundary_s;
  logic [7:0]        field_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // A SYNC seen outside LOCKED (acquire or realign) always marks bit 0 of a new frame.
  always_comb begin
    boundary_s = (bit_cnt_q == {CW{1'b0}});
    bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? {CW{1'b0}} : bit_cnt_q + CNT_ONE;
    err_d      = sat_inc8(err_q);
    if ((state_q != ST_LOCKED) && SYNC_IN) begin
      wr_idx_s = {CW{1'b0}};
    end else begin
      wr_idx_s = bit_cnt_q;
    end
    shift_d = shift_q;
    for (int k = 0; k < WORD_W - 1; k++) begin
      if (wr_idx_s == CW'(k)) begin
        shift_d[k] = DATA_IN;
      end else begin
        shift_d[k] = shift_q[k];
      end
    end
  end

  // Framing FSM, word assembly and error accounting.
  always_ff @(posedge SER_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= {CW{1'b0}};
      good_cnt_q <= 4'd0;
      miss_cnt_q <= 4'd0;
      shift_q    <= {(WORD_W-1){1'b0}};
      word_q     <= {WORD_W{1'b0}};
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 8'd0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_HUNT: begin
          if (SYNC_IN) begin
            shift_q    <= shift_d;
            bit_cnt_q  <= CNT_ONE;
            good_cnt_q <= 4'd1;
            miss_cnt_q <= 4'd0;
            if (LOCK_N == 4'd1) begin
              state_q  <= ST_LOCKED;
              locked_q <= 1'b1;
            end else begin
              state_q  <= ST_VERIFY;
            end
          end else begin
            bit_cnt_q <= {CW{1'b0}};
          end
        end
        ST_VERIFY: begin
          shift_q <= shift_d;
          if (boundary_s) begin
            if (SYNC_IN) begin
              good_cnt_q <= good_cnt_q + 4'd1;
              bit_cnt_q  <= CNT_ONE;
              if (good_cnt_q + 4'd1 == LOCK_N) begin
                state_q    <= ST_LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= 4'd0;
              end
            end else begin
              state_q    <= ST_HUNT;
              bit_cnt_q  <= {CW{1'b0}};
              good_cnt_q <= 4'd0;
            end
          end else if (SYNC_IN) begin
            bit_cnt_q  <= CNT_ONE;
            good_cnt_q <= 4'd1;
          end else begin
            bit_cnt_q  <= bit_cnt_d;
          end
        end
        ST_LOCKED: begin
          shift_q   <= shift_d;
          bit_cnt_q <= bit_cnt_d;
          if (boundary_s) begin
            if (SYNC_IN) begin
              miss_cnt_q <= 4'd0;
            end else begin
              err_q <= err_d;
              if (miss_cnt_q + 4'd1 == LOSS_N) begin
                // Losing lock drops this frame: it never reaches the word register.
                state_q    <= ST_HUNT;
                locked_q   <= 1'b0;
                bit_cnt_q  <= {CW{1'b0}};
                miss_cnt_q <= 4'd0;
                good_cnt_q <= 4'd0;
              end else begin
                miss_cnt_q <= miss_cnt_q + 4'd1;
              end
            end
          end else if (SYNC_IN) begin
            err_q <= err_d;
          end
          if (bit_cnt_q == LAST_BIT) begin
            word_q  <= {DATA_IN, shift_q};
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_HUNT;
          bit_cnt_q  <= {CW{1'b0}};
          good_cnt_q <= 4'd0;
          miss_cnt_q <= 4'd0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  if (WORD_W >= 8) begin : g_fields_wide
    assign field_s = word_q[WORD_W-1 -: 8];
  end else begin : g_fields_narrow
    assign field_s = {word_q, {(8-WORD_W){1'b0}}};
  end

  assign WORD_OUT   = word_q;
  assign WORD_VALID = valid_q;
  assign LOCKED     = locked_q;
  assign ERR_COUNT  = err_q;
  assign R0_I       = field_s[7:6];
  assign R0_Q       = field_s[5:4];
  assign R1_I       = field_s[3:2];
  assign R1_Q       = field_s[1:0];

endmodule

// File: tb/tb_radio_deser.sv
// Directed bench for radio_deser: acquisition, flywheel, loss, spurious SYNC,
// mid-frame reset and error-counter saturation with hand-computed expectations.
module tb_radio_deser;

  logic       SER_CLK = 1'b0;
  logic       RST_N;
  logic       DATA_IN;
  logic       SYNC_IN;
  logic [7:0] WORD_OUT;
  logic       WORD_VALID;
  logic [1:0] R0_I, R0_Q, R1_I, R1_Q;
  logic       LOCKED;
  logic [7:0] ERR_COUNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount = 0;
  int vcyc = 0;
  int prev_vcyc = 0;
  int vc_snap = 0;
  logic [7:0] vword = 8'h00;
  logic [1:0] vr0i, vr0q, vr1i, vr1q;
  logic       lk0;

  radio_deser #(.WORD_W(8), .LOCK_COUNT(4), .LOSS_COUNT(2)) dut (
    .SER_CLK(SER_CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .SYNC_IN(SYNC_IN),
    .WORD_OUT(WORD_OUT), .WORD_VALID(WORD_VALID),
    .R0_I(R0_I), .R0_Q(R0_Q), .R1_I(R1_I), .R1_Q(R1_Q),
    .LOCKED(LOCKED), .ERR_COUNT(ERR_COUNT)
  );

  always #5 SER_CLK = ~SER_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the DUT sample it, then record any strobe.
  task automatic send_bit(input logic d, input logic s);
    DATA_IN = d;
    SYNC_IN = s;
    @(posedge SER_CLK);
    #1;
    cyc++;
    if (WORD_VALID === 1'b1) begin
      vcount++;
      prev_vcyc = vcyc;
      vcyc  = cyc;
      vword = WORD_OUT;
      vr0i = R0_I; vr0q = R0_Q; vr1i = R1_I; vr1q = R1_Q;
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input logic [7:0] smask);
    for (int k = 0; k < 8; k++) begin
      send_bit(w[k], smask[k]);
      if (k == 0) lk0 = LOCKED;
    end
  endtask

  initial begin
    RST_N = 1'b0; DATA_IN = 1'b0; SYNC_IN = 1'b0;
    repeat (2) @(posedge SER_CLK);
    #1;
    chk("rst_word", WORD_OUT, 8'h00);
    chk("rst_valid", WORD_VALID, 1'b0);
    chk("rst_locked", LOCKED, 1'b0);
    chk("rst_err", ERR_COUNT, 8'h00);
    RST_N = 1'b1;

    // Acquisition
    send_frame(8'hA5, 8'h01);
    send_frame(8'h3C, 8'h01);
    send_frame(8'h81, 8'h01);
    chk("acq_not_locked", LOCKED, 1'b0);
    chk("acq_no_word", vcount, 0);
    send_frame(8'h7E, 8'h01);
    chk("acq_lock_bit0", lk0, 1'b1);
    chk("acq_first_cnt", vcount, 1);
    chk("acq_first_word", vword, 8'h7E);
    chk("acq_7e_fields", {vr0i, vr0q, vr1i, vr1q}, 8'h7E);
    send_frame(8'h12, 8'h01);
    chk("acq_second_cnt", vcount, 2);
    chk("acq_second_word", vword, 8'h12);
    chk("acq_spacing", vcyc - prev_vcyc, 8);
    chk("acq_r0_i", vr0i, 2'd0);
    chk("acq_r0_q", vr0q, 2'd1);
    chk("acq_r1_i", vr1i, 2'd0);
    chk("acq_r1_q", vr1q, 2'd2);
    chk("acq_err", ERR_COUNT, 8'd0);

    // Flywheel
    send_frame(8'h5A, 8'h01);
    chk("fly_pre_word", vword, 8'h5A);
    send_frame(8'hC3, 8'h00);
    chk("fly_word", vword, 8'hC3);
    chk("fly_locked", LOCKED, 1'b1);
    chk("fly_err1", ERR_COUNT, 8'd1);
    send_frame(8'h0F, 8'h01);
    chk("fly_resume_word", vword, 8'h0F);
    send_frame(8'h99, 8'h00);
    chk("fly2_locked", LOCKED, 1'b1);
    chk("fly2_word", vword, 8'h99);
    chk("fly2_err", ERR_COUNT, 8'd2);
    send_frame(8'h66, 8'h01);

    // Loss: two consecutive misses
    send_frame(8'h11, 8'h00);
    chk("loss_first_word", vword, 8'h11);
    chk("loss_first_locked", LOCKED, 1'b1);
    vc_snap = vcount;
    send_frame(8'h22, 8'h00);
    chk("loss_drop_bit0", lk0, 1'b0);
    chk("loss_not_emitted", vcount, vc_snap);
    chk("loss_hold_word", WORD_OUT, 8'h11);
    chk("loss_err", ERR_COUNT, 8'd4);
    send_frame(8'h01, 8'h01);
    send_frame(8'h02, 8'h01);
    send_frame(8'h03, 8'h01);
    chk("relock_pending", LOCKED, 1'b0);
    chk("relock_no_word", vcount, vc_snap);
    send_frame(8'h04, 8'h01);
    chk("relock_locked", LOCKED, 1'b1);
    chk("relock_word", vword, 8'h04);

    // Spurious SYNC while locked
    send_frame(8'h3B, 8'h09);
    chk("spur_lk_err", ERR_COUNT, 8'd5);
    chk("spur_lk_word", vword, 8'h3B);
    send_frame(8'h4C, 8'h01);
    chk("spur_lk_align", vword, 8'h4C);
    chk("spur_lk_locked", LOCKED, 1'b1);
    chk("spur_lk_err_hold", ERR_COUNT, 8'd5);

    // Spurious SYNC while verifying restarts the good count
    send_frame(8'h00, 8'h00);
    send_frame(8'h00, 8'h00);
    chk("spur_vf_lost", LOCKED, 1'b0);
    chk("spur_vf_err", ERR_COUNT, 8'd7);
    send_frame(8'hAA, 8'h01);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    vc_snap = vcount;
    send_frame(8'hE1, 8'h01);
    send_frame(8'hE2, 8'h01);
    send_frame(8'hE3, 8'h01);
    chk("spur_vf_pending", LOCKED, 1'b0);
    chk("spur_vf_no_word", vcount, vc_snap);
    send_frame(8'hE4, 8'h01);
    chk("spur_vf_locked", LOCKED, 1'b1);
    chk("spur_vf_word", vword, 8'hE4);
    chk("spur_vf_err_hold", ERR_COUNT, 8'd7);

    // Reset at bit 5 of a locked frame
    for (int k = 0; k < 5; k++) send_bit(k[0], (k == 0) ? 1'b1 : 1'b0);
    vc_snap = vcount;
    RST_N = 1'b0;
    #1;
    chk("mrst_word", WORD_OUT, 8'h00);
    chk("mrst_valid", WORD_VALID, 1'b0);
    chk("mrst_locked", LOCKED, 1'b0);
    chk("mrst_err", ERR_COUNT, 8'h00);
    chk("mrst_r0_i", R0_I, 2'd0);
    repeat (2) @(posedge SER_CLK);
    #1;
    chk("mrst_hold_valid", WORD_VALID, 1'b0);
    RST_N = 1'b1;
    send_frame(8'hA5, 8'h01);
    send_frame(8'h3C, 8'h01);
    send_frame(8'h81, 8'h01);
    chk("reacq_not_locked", LOCKED, 1'b0);
    chk("reacq_no_word", vcount, vc_snap);
    send_frame(8'h7E, 8'h01);
    chk("reacq_lock_bit0", lk0, 1'b1);
    chk("reacq_first_word", vword, 8'h7E);
    send_frame(8'h12, 8'h01);
    chk("reacq_second_word", vword, 8'h12);
    chk("reacq_err", ERR_COUNT, 8'd0);

    // Saturation: 7 spurious SYNCs per frame
    for (int f = 0; f < 36; f++) send_frame(8'h5A, 8'hFF);
    chk("sat_252", ERR_COUNT, 8'd252);
    for (int f = 0; f < 7; f++) send_frame(8'h5A, 8'hFF);
    chk("sat_255", ERR_COUNT, 8'd255);
    send_frame(8'h5A, 8'hFF);
    send_frame(8'h5A, 8'hFF);
    chk("sat_hold", ERR_COUNT, 8'd255);
    chk("sat_locked", LOCKED, 1'b1);
    chk("sat_word", vword, 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
